// File: rtl/hilo_pkg.sv
// Shared encodings and nominal latencies for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULTU = 3'd1,
    OP_MULT  = 3'd2,
    OP_DIVU  = 3'd3,
    OP_DIV   = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  // Start-to-EN latencies for the default 32-bit datapath.
  localparam int DEFAULT_WIDTH = 32;
  localparam int MUL_CYCLES    = DEFAULT_WIDTH + 2;
  localparam int DIV_CYCLES    = DEFAULT_WIDTH + 2;
  localparam int DIV0_CYCLES   = 2;
  localparam int MT_CYCLES     = 1;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_dp.sv
// Iterative datapath: operand magnitudes, shift-add multiply / restoring divide
// step, and combinational two's-complement sign fixup of the final result.
module muldiv_iter_dp
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Load,
  input  logic             IsDiv,
  input  logic             IsSigned,
  input  logic             Step,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             RestZero,
  output logic [WIDTH-1:0] ResHi,
  output logic [WIDTH-1:0] ResLo
);

  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [WIDTH-1:0]   divisor_reg, divisor_next;
  logic               is_div_reg, is_div_next;
  logic               neg_hi_reg, neg_hi_next;
  logic               neg_lo_reg, neg_lo_next;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   hi_neg, lo_neg;

  always_comb begin
    sign_a = IsSigned & SrcA[WIDTH-1];
    sign_b = IsSigned & SrcB[WIDTH-1];
    mag_a  = sign_a ? -SrcA : SrcA;
    mag_b  = sign_b ? -SrcB : SrcB;
  end

  // Partial remainder is one bit wider than the divisor after the left shift.
  always_comb begin
    rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor_reg};
  end

  always_comb begin
    acc_next     = acc_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    divisor_next = divisor_reg;
    is_div_next  = is_div_reg;
    neg_hi_next  = neg_hi_reg;
    neg_lo_next  = neg_lo_reg;
    if (Load) begin
      is_div_next = IsDiv;
      neg_lo_next = sign_a ^ sign_b;
      neg_hi_next = IsDiv ? sign_a : (sign_a ^ sign_b);
      if (IsDiv) begin
        acc_next     = {{WIDTH{1'b0}}, mag_a};
        divisor_next = mag_b;
        mcand_next   = '0;
        mplier_next  = '0;
      end else begin
        acc_next     = '0;
        mcand_next   = {{WIDTH{1'b0}}, mag_a};
        mplier_next  = mag_b;
        divisor_next = '0;
      end
    end else if (Step) begin
      if (is_div_reg) begin
        if (!rem_diff[WIDTH])
          acc_next = {rem_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
          acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end else begin
        if (mplier_reg[0])
          acc_next = acc_reg + mcand_reg;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      divisor_reg <= '0;
      is_div_reg  <= 1'b0;
      neg_hi_reg  <= 1'b0;
      neg_lo_reg  <= 1'b0;
    end else begin
      acc_reg     <= acc_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      divisor_reg <= divisor_next;
      is_div_reg  <= is_div_next;
      neg_hi_reg  <= neg_hi_next;
      neg_lo_reg  <= neg_lo_next;
    end
  end

  // Multiplier bits still to be consumed after the current step.
  assign RestZero = (mplier_reg[WIDTH-1:1] == '0);

  // A product negates as one 2W-bit value; quotient and remainder negate separately.
  always_comb begin
    acc_neg = -acc_reg;
    hi_neg  = -acc_reg[2*WIDTH-1:WIDTH];
    lo_neg  = -acc_reg[WIDTH-1:0];
    if (is_div_reg) begin
      ResHi = neg_hi_reg ? hi_neg : acc_reg[2*WIDTH-1:WIDTH];
      ResLo = neg_lo_reg ? lo_neg : acc_reg[WIDTH-1:0];
    end else begin
      ResHi = neg_hi_reg ? acc_neg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
      ResLo = neg_lo_reg ? acc_neg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter and pipeline handshake.
// Define MULDIV_EARLY_OUT_EN to let MUL finish once the remaining multiplier bits are zero.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] HiIn,
  input  logic [WIDTH-1:0] LoIn,
  input  logic             Read,
  output logic [WIDTH-1:0] DLo,
  output logic [WIDTH-1:0] DHi,
  output logic             EN,
  output logic             Busy,
  output logic             Stall,
  output logic             DivZero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] dlo_reg, dlo_next;
  logic [WIDTH-1:0] dhi_reg, dhi_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;
  logic             dz_reg, dz_next;

  logic             dp_load, dp_step, dp_is_div, dp_signed;
  logic             rest_zero;
  logic [WIDTH-1:0] res_hi, res_lo;

  muldiv_iter_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .CLK      (CLK),
    .RST      (RST),
    .Load     (dp_load),
    .IsDiv    (dp_is_div),
    .IsSigned (dp_signed),
    .Step     (dp_step),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .RestZero (rest_zero),
    .ResHi    (res_hi),
    .ResLo    (res_lo)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dlo_next   = dlo_reg;
    dhi_next   = dhi_reg;
    en_next    = 1'b0;
    dz_next    = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    dp_is_div  = op_is_div(Op);
    dp_signed  = op_is_signed(Op);
    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            OP_MTHI: begin
              dhi_next = SrcA;
              dlo_next = LoIn;
              en_next  = 1'b1;
            end
            OP_MTLO: begin
              dlo_next = SrcA;
              dhi_next = HiIn;
              en_next  = 1'b1;
            end
            OP_MULTU, OP_MULT: begin
              dp_load    = 1'b1;
              cnt_next   = '0;
              state_next = (EARLY_OUT && (SrcB == '0)) ? S_FIX : S_MUL;
            end
            OP_DIVU, OP_DIV: begin
              if (SrcB == '0) begin
                dhi_next   = SrcA;
                dlo_next   = '1;
                state_next = S_DONE;
              end else begin
                dp_load    = 1'b1;
                cnt_next   = '0;
                state_next = S_DIV;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        dp_step  = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if ((cnt_reg == LAST_ITER) || (EARLY_OUT && rest_zero))
          state_next = S_FIX;
      end
      S_DIV: begin
        dp_step  = 1'b1;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_ITER)
          state_next = S_FIX;
      end
      S_FIX: begin
        dhi_next   = res_hi;
        dlo_next   = res_lo;
        en_next    = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        // Arriving from FIX the write pulse is already up; a divide-by-zero raises it here.
        if (en_reg) begin
          state_next = S_IDLE;
        end else begin
          en_next = 1'b1;
          dz_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      dlo_reg   <= '0;
      dhi_reg   <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dlo_reg   <= dlo_next;
      dhi_reg   <= dhi_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      dz_reg    <= dz_next;
    end
  end

  assign DLo     = dlo_reg;
  assign DHi     = dhi_reg;
  assign EN      = en_reg;
  assign Busy    = busy_reg;
  assign DivZero = dz_reg;
  assign Stall   = busy_reg & (Read | Start);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO results queued at issue, popped on EN.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST, Start, Read;
  logic [2:0]   Op;
  logic [W-1:0] SrcA, SrcB, HiIn, LoIn;
  logic [W-1:0] DLo, DHi;
  logic         EN, Busy, Stall, DivZero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_count = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;
  exp_t scoreboard[$];

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiIn(HiIn), .LoIn(LoIn), .Read(Read), .DLo(DLo), .DHi(DHi), .EN(EN),
    .Busy(Busy), .Stall(Stall), .DivZero(DivZero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (EN === 1'b1) en_count <= en_count + 1;

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b, hi_in, lo_in,
                                output logic [W-1:0] hi, lo, output logic dz);
    longint sa, sbv, q, r;
    logic [63:0] p;
    hi = hi_in; lo = lo_in; dz = 1'b0;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      OP_MULTU: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; end
      OP_MULT:  begin p = 64'(sa * sbv); hi = p[63:32]; lo = p[31:0]; end
      OP_DIVU, OP_DIV: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1;
        end else if (op == OP_DIVU) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sbv; r = sa % sbv;
          lo = 32'(q); hi = 32'(r);
        end
      end
      OP_MTHI: begin hi = a; lo = lo_in; end
      OP_MTLO: begin lo = a; hi = hi_in; end
      default: ;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    logic [W-1:0] mag;
    int msb;
`endif
    case (op)
      OP_MTHI, OP_MTLO: return 1;
      OP_DIVU, OP_DIV:  return (b == '0) ? 2 : W + 2;
      OP_MULTU, OP_MULT: begin
`ifdef MULDIV_EARLY_OUT_EN
        mag = (op == OP_MULT && b[W-1]) ? -b : b;
        if (mag == '0) return 2;
        msb = 0;
        for (int i = 0; i < W; i++) if (mag[i]) msb = i;
        return msb + 3;
`else
        return W + 2;
`endif
      end
      default: return 0;
    endcase
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Called #1 after a rising edge; holds Start across exactly one edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b, input bit push);
    exp_t e;
    logic [W-1:0] h, l;
    logic z;
    model(op, a, b, HiIn, LoIn, h, l, z);
    e.hi = h; e.lo = l; e.dz = z;
    e.due = cyc + latency(op, b);
    if (push) scoreboard.push_back(e);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    tick(1);
    Start = 1'b0; Op = OP_NOP;
  endtask

  task automatic wait_en(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge CLK);
      if (EN === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; Read = 1'b0; Op = OP_NOP;
    SrcA = '0; SrcB = '0; HiIn = '0; LoIn = '0;
    tick(3);
    checks++;
    if ({DLo, DHi, EN, Busy, DivZero, Stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got DLo=%h DHi=%h EN=%b Busy=%b DZ=%b Stall=%b want all zero",
               DLo, DHi, EN, Busy, DivZero, Stall);
    end
    RST = 1'b0;
    tick(1);
  endtask

  task automatic test_multu_busy();
    bit seen, busy_ok;
    exp_t e;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    busy_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (EN === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL multu_busy Busy dropped before EN, want 1"); end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL multu_timeout EN=0 want 1 within 60 cycles");
    end else begin
      e = scoreboard.pop_front();
      checks++;
      if ({DHi, DLo, DivZero} !== {e.hi, e.lo, e.dz}) begin
        errors++; $display("FAIL multu_result got %h_%h dz=%b want %h_%h dz=%b", DHi, DLo, DivZero, e.hi, e.lo, e.dz);
      end
      checks++;
      if (cyc !== e.due) begin errors++; $display("FAIL multu_latency got cycle %0d want %0d", cyc, e.due); end
    end
    @(negedge CLK);
    checks++;
    if ({EN, Busy} !== 2'b00) begin errors++; $display("FAIL multu_after got EN=%b Busy=%b want 0 0", EN, Busy); end
    tick(1);
  endtask

  task automatic test_arith_table();
    logic [2:0]   ops[8] = '{OP_MULT, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_MULTU, OP_MULT, OP_DIVU};
    logic [W-1:0] as[8]  = '{-32'sd3, -32'sd7, 32'd100, 32'h8000_0000, -32'sd5, 32'd12345, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] bs[8]  = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd1};
    bit seen;
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      issue(ops[k], as[k], bs[k], 1'b1);
      wait_en(60, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL table%0d_timeout EN=0 want 1", k);
        void'(scoreboard.pop_front());
      end else begin
        e = scoreboard.pop_front();
        checks++;
        if ({DHi, DLo, DivZero} !== {e.hi, e.lo, e.dz}) begin
          errors++; $display("FAIL table%0d_result got %h_%h dz=%b want %h_%h dz=%b", k, DHi, DLo, DivZero, e.hi, e.lo, e.dz);
        end
        checks++;
        if (cyc !== e.due) begin errors++; $display("FAIL table%0d_latency got cycle %0d want %0d", k, cyc, e.due); end
      end
      tick(1);
    end
  endtask

  task automatic test_random();
    bit seen;
    exp_t e;
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int k = 0; k < 12; k++) begin
      op = 3'($urandom_range(1, 4));
      a = $urandom;
      b = (k % 2 == 1) ? 32'($urandom_range(0, 300)) : $urandom;
      issue(op, a, b, 1'b1);
      wait_en(60, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL rand%0d_timeout EN=0 want 1", k);
        void'(scoreboard.pop_front());
      end else begin
        e = scoreboard.pop_front();
        checks++;
        if ({DHi, DLo, DivZero, cyc} !== {e.hi, e.lo, e.dz, e.due}) begin
          errors++; $display("FAIL rand%0d op=%0d a=%h b=%h got %h_%h dz=%b cyc=%0d want %h_%h dz=%b cyc=%0d",
                             k, op, a, b, DHi, DLo, DivZero, cyc, e.hi, e.lo, e.dz, e.due);
        end
      end
      tick(1);
    end
  endtask

  task automatic test_mt();
    bit seen;
    exp_t e;
    HiIn = 32'h5555_5555; LoIn = 32'hAAAA_0000;
    for (int k = 0; k < 2; k++) begin
      issue((k == 0) ? OP_MTHI : OP_MTLO, (k == 0) ? 32'h1234_5678 : 32'h0BAD_F00D, 32'd0, 1'b1);
      wait_en(3, seen);
      checks++;
      if (!seen) begin
        errors++; $display("FAIL mt%0d_timeout EN=0 want 1", k);
        void'(scoreboard.pop_front());
      end else begin
        e = scoreboard.pop_front();
        checks++;
        if ({DHi, DLo, Busy, cyc} !== {e.hi, e.lo, 1'b0, e.due}) begin
          errors++; $display("FAIL mt%0d got %h_%h busy=%b cyc=%0d want %h_%h busy=0 cyc=%0d",
                             k, DHi, DLo, Busy, cyc, e.hi, e.lo, e.due);
        end
      end
      tick(1);
    end
    HiIn = '0; LoIn = '0;
  endtask

  task automatic test_stall_and_ignore();
    bit seen, stall_ok;
    int en_before;
    exp_t e;
    Read = 1'b1;
    tick(1);
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL stall_idle got %b want 0", Stall); end
    en_before = en_count;
    issue(OP_MULT, -32'sd9, 32'h0001_0005, 1'b1);
    stall_ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (i == 1) begin Start = 1'b1; Op = OP_MTHI; SrcA = 32'hDEAD_BEEF; end
      if (i == 2) begin Start = 1'b0; Op = OP_NOP; end
      if (Stall !== 1'b1) stall_ok = 1'b0;
      if (EN === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!stall_ok) begin errors++; $display("FAIL stall_busy Stall dropped before EN, want 1"); end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL stall_timeout EN=0 want 1");
      void'(scoreboard.pop_front());
    end else begin
      e = scoreboard.pop_front();
      checks++;
      if ({DHi, DLo, cyc} !== {e.hi, e.lo, e.due}) begin
        errors++; $display("FAIL stall_result got %h_%h cyc=%0d want %h_%h cyc=%0d", DHi, DLo, cyc, e.hi, e.lo, e.due);
      end
    end
    tick(4);
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL stall_after got %b want 0", Stall); end
    checks++;
    if (en_count !== en_before + 1) begin
      errors++; $display("FAIL ignored_start EN pulses got %0d want 1", en_count - en_before);
    end
    Read = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    int en_before;
    exp_t e;
    en_before = en_count;
    issue(OP_DIV, 32'd1000, 32'd7, 1'b0);
    tick(9);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checks++;
    if ({DLo, DHi, EN, Busy, DivZero} !== '0) begin
      errors++; $display("FAIL midreset_outputs got DLo=%h DHi=%h EN=%b Busy=%b DZ=%b want zero", DLo, DHi, EN, Busy, DivZero);
    end
    tick(40);
    checks++;
    if (en_count !== en_before) begin
      errors++; $display("FAIL midreset_no_en EN pulses got %0d want 0", en_count - en_before);
    end
    issue(OP_MULTU, 32'h0001_0001, 32'h0001_0001, 1'b1);
    wait_en(60, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL postreset_timeout EN=0 want 1");
      void'(scoreboard.pop_front());
    end else begin
      e = scoreboard.pop_front();
      checks++;
      if ({DHi, DLo, cyc} !== {e.hi, e.lo, e.due}) begin
        errors++; $display("FAIL postreset_result got %h_%h cyc=%0d want %h_%h cyc=%0d", DHi, DLo, cyc, e.hi, e.lo, e.due);
      end
    end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_multu_busy();
    test_arith_table();
    test_mt();
    test_stall_and_ignore();
    test_random();
    test_reset_mid_op();
    checks++;
    if (scoreboard.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got %0d entries want 0", scoreboard.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
